// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Package : simon_pkg
// Shared state encoding, one-hot decode and LFSR tap masks for the Simon game.
// Rev     : 1.0
// ============================================================================
package simon_pkg;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_GEN      = 3'd1;
    localparam logic [2:0] c_ST_SHOW_ON  = 3'd2;
    localparam logic [2:0] c_ST_SHOW_GAP = 3'd3;
    localparam logic [2:0] c_ST_WAIT_KEY = 3'd4;
    localparam logic [2:0] c_ST_ECHO     = 3'd5;
    localparam logic [2:0] c_ST_WIN      = 3'd6;
    localparam logic [2:0] c_ST_LOSE     = 3'd7;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

    // Right-shifting Galois feedback masks of maximal-length polynomials
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            3:       lfsr_taps = 64'h6;
            4:       lfsr_taps = 64'hC;
            5:       lfsr_taps = 64'h14;
            6:       lfsr_taps = 64'h30;
            7:       lfsr_taps = 64'h60;
            8:       lfsr_taps = 64'hB8;
            16:      lfsr_taps = 64'hB400;
            24:      lfsr_taps = 64'hE10000;
            32:      lfsr_taps = 64'hA3000000;
            default: lfsr_taps = 64'd1 << (width - 1);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_lfsr.sv
`default_nettype none
// ============================================================================
// Module : simon_lfsr
// Free-running Galois LFSR, advances every clock, reloads SEED on reset.
// Rev    : 1.0
// ============================================================================
module simon_lfsr
    import simon_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clock,
    input  logic              n_reset,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] c_TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            q <= SEED;
        end else begin
            q <= (q >> 1) ^ (q[0] ? c_TAPS : '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/simon_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module : simon_game_ctrl
// Simon memory-game controller: grows a random sequence, plays it, checks echoes.
// Build option SIMON_TIMEOUT_EN: lose after TIMEOUT_CYC idle cycles in WAIT_KEY.
// Rev    : 1.0
// ============================================================================
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int                N_CH     = 4,
    parameter int                MAX_LEN  = 16,
    parameter int                SHOW_CYC = 25000000,
    parameter int                GAP_CYC  = 12500000,
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
`ifdef SIMON_TIMEOUT_EN
    ,
    parameter int                TIMEOUT_CYC = 250000000
`endif
) (
    input  logic                         clock,
    input  logic                         n_reset,
    input  logic                         start,
    input  logic [N_CH-1:0]              key,
    output logic [N_CH-1:0]              led,
    output logic                         busy,
    output logic                         won,
    output logic                         lost,
    output logic [$clog2(MAX_LEN+1)-1:0] level
);

    localparam int c_IDX_W = $clog2(N_CH);
    localparam int c_LVL_W = $clog2(MAX_LEN + 1);
    localparam int c_PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef SIMON_TIMEOUT_EN
    localparam int c_TMO_CYC = TIMEOUT_CYC;
`else
    localparam int c_TMO_CYC = 1;
`endif
    localparam int c_MAX_SG  = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int c_CNT_MAX = (c_MAX_SG > c_TMO_CYC) ? c_MAX_SG : c_TMO_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SHOW_LD = c_CNT_W'(SHOW_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD  = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LD  = c_CNT_W'(c_TMO_CYC - 1);

    logic [2:0]         r_state;
    logic [c_LVL_W-1:0] r_level;
    logic [c_PTR_W-1:0] r_pos;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_flash;
    logic               r_start_d;
    logic [N_CH-1:0]    r_key_d;
    logic [c_IDX_W-1:0] r_seq [MAX_LEN];

    logic [LFSR_W-1:0]  w_lfsr;
    logic [c_IDX_W-1:0] w_new;
    logic               w_start_rise;
    logic [N_CH-1:0]    w_key_rise;
    logic [N_CH-1:0]    w_cur_oh;
    logic [c_LVL_W-1:0] w_pos_inc;
    logic               w_more;
    logic               w_cnt_done;

    simon_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clock   (clock),
        .n_reset (n_reset),
        .q       (w_lfsr)
    );

    assign w_new        = c_IDX_W'(w_lfsr);
    assign w_start_rise = start & ~r_start_d;
    assign w_key_rise   = key & ~r_key_d;
    assign w_cur_oh     = N_CH'(onehot16(4'(r_seq[r_pos])));
    assign w_pos_inc    = c_LVL_W'(r_pos) + c_LVL_W'(1);
    assign w_more       = (w_pos_inc < r_level);
    assign w_cnt_done   = (r_cnt == '0);

    // Sequence storage needs no reset: entries are only read after being written
    always_ff @(posedge clock) begin
        if (r_state == c_ST_GEN) begin
            r_seq[r_level[c_PTR_W-1:0]] <= w_new;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= c_ST_IDLE;
            r_level   <= '0;
            r_pos     <= '0;
            r_cnt     <= '0;
            r_flash   <= 1'b0;
            r_start_d <= 1'b0;
            r_key_d   <= '0;
        end else begin
            r_start_d <= start;
            r_key_d   <= key;
            case (r_state)
                c_ST_IDLE, c_ST_WIN, c_ST_LOSE: begin
                    if (r_state == c_ST_LOSE) begin
                        if (!w_cnt_done) r_cnt   <= r_cnt - c_CNT_W'(1);
                        else             r_flash <= 1'b0;
                    end
                    if (w_start_rise) begin
                        r_level <= '0;
                        r_pos   <= '0;
                        r_flash <= 1'b0;
                        r_state <= c_ST_GEN;
                    end
                end
                c_ST_GEN: begin
                    r_level <= r_level + c_LVL_W'(1);
                    r_pos   <= '0;
                    r_cnt   <= c_SHOW_LD;
                    r_state <= c_ST_SHOW_ON;
                end
                c_ST_SHOW_ON: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        r_cnt   <= c_GAP_LD;
                        r_state <= c_ST_SHOW_GAP;
                    end
                end
                c_ST_SHOW_GAP: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else if (w_more) begin
                        r_pos   <= r_pos + c_PTR_W'(1);
                        r_cnt   <= c_SHOW_LD;
                        r_state <= c_ST_SHOW_ON;
                    end else begin
                        r_pos   <= '0;
                        r_cnt   <= c_TMO_LD;
                        r_state <= c_ST_WAIT_KEY;
                    end
                end
                c_ST_WAIT_KEY: begin
                    // A lone edge on the expected channel is the only accepted press
                    if (w_key_rise != '0) begin
                        r_cnt <= c_SHOW_LD;
                        if (w_key_rise == w_cur_oh) begin
                            r_state <= c_ST_ECHO;
                        end else begin
                            r_flash <= 1'b1;
                            r_state <= c_ST_LOSE;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (w_cnt_done) begin
                        r_cnt   <= c_SHOW_LD;
                        r_flash <= 1'b1;
                        r_state <= c_ST_LOSE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
`endif
                end
                c_ST_ECHO: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        r_pos <= r_pos + c_PTR_W'(1);
                        if (w_more) begin
                            r_cnt   <= c_TMO_LD;
                            r_state <= c_ST_WAIT_KEY;
                        end else if (r_level == c_LVL_W'(MAX_LEN)) begin
                            r_state <= c_ST_WIN;
                        end else begin
                            r_state <= c_ST_GEN;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        led = '0;
        case (r_state)
            c_ST_SHOW_ON, c_ST_ECHO: led = w_cur_oh;
            c_ST_WIN:                led = '1;
            c_ST_LOSE:               led = {N_CH{r_flash}};
            default:                 led = '0;
        endcase
    end

    assign busy  = (r_state != c_ST_IDLE) && (r_state != c_ST_WIN) && (r_state != c_ST_LOSE);
    assign won   = (r_state == c_ST_WIN);
    assign lost  = (r_state == c_ST_LOSE);
    assign level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_simon_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_simon_game_ctrl
// Self-checking bench: vector table, random games and directed corner cases.
// Rev    : 1.0
// ============================================================================
module tb_simon_game_ctrl;

    localparam int N_CH     = 4;
    localparam int MAX_LEN  = 3;
    localparam int SHOW_CYC = 4;
    localparam int GAP_CYC  = 2;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef SIMON_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 20;
`endif

    logic       clock   = 1'b0;
    logic       n_reset = 1'b1;
    logic       start   = 1'b0;
    logic [3:0] key     = 4'd0;
    logic [3:0] led;
    logic       busy;
    logic       won;
    logic       lost;
    logic [1:0] level;

    int total = 0;
    int bad   = 0;
    int exp_seq[$];
    int exp_level;
    logic [15:0] m_lfsr;

    simon_game_ctrl #(
        .N_CH     (N_CH),
        .MAX_LEN  (MAX_LEN),
        .SHOW_CYC (SHOW_CYC),
        .GAP_CYC  (GAP_CYC),
        .LFSR_W   (16),
        .SEED     (SEED)
`ifdef SIMON_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
    ) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .start   (start),
        .key     (key),
        .led     (led),
        .busy    (busy),
        .won     (won),
        .lost    (lost),
        .level   (level)
    );

    always #5 clock = ~clock;

    // Reference random source: x^16+x^14+x^13+x^11+1, right-shifting Galois form
    always @(posedge clock or negedge n_reset) begin
        if (!n_reset) m_lfsr <= SEED;
        else          m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [3:0] oh(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    function automatic logic [8:0] outs(input logic [3:0] l, input bit b, input bit w,
                                        input bit lo, input int lvl);
        return {l, b, w, lo, 2'(lvl)};
    endfunction

    task automatic chk_out(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {led, busy, won, lost, level};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got led=%b busy=%b won=%b lost=%b level=%0d, want led=%b busy=%b won=%b lost=%b level=%0d",
                     name, act[8:5], act[4], act[3], act[2], act[1:0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        start   = 1'b0;
        key     = 4'd0;
        #1;
        chk_out("reset_now", outs(4'h0, 0, 0, 0, 0));
        tick();
        tick();
        n_reset   = 1'b1;
        exp_level = 0;
        exp_seq.delete();
    endtask

    // Current sample is a GEN cycle: the element drawn is the LFSR value now visible
    task automatic gen_step();
        chk_out("gen", outs(4'h0, 1, 0, 0, exp_level));
        exp_seq.push_back(int'(m_lfsr[1:0]));
        exp_level++;
    endtask

    task automatic start_game(input int delay);
        repeat (delay) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_level = 0;
        exp_seq.delete();
        gen_step();
    endtask

    task automatic play_round(input bit noise);
        for (int p = 0; p < exp_level; p++) begin
            for (int c = 0; c < SHOW_CYC; c++) begin
                tick();
                chk_out("show", outs(oh(exp_seq[p]), 1, 0, 0, exp_level));
                if (noise) begin
                    key   = 4'($urandom_range(0, 15));
                    start = 1'($urandom_range(0, 1));
                end
            end
            key   = 4'd0;
            start = 1'b0;
            for (int g = 0; g < GAP_CYC; g++) begin
                tick();
                chk_out("gap", outs(4'h0, 1, 0, 0, exp_level));
            end
        end
        tick();
        chk_out("wait_entry", outs(4'h0, 1, 0, 0, exp_level));
    endtask

    task automatic echo(input int ch, input bit noise);
        for (int c = 0; c < SHOW_CYC; c++) begin
            if (c > 0) tick();
            chk_out("echo", outs(oh(ch), 1, 0, 0, exp_level));
            if (noise && c < SHOW_CYC - 2) key = 4'($urandom_range(0, 15));
            else                           key = 4'd0;
        end
    endtask

    task automatic lose_check(input int lvl);
        for (int c = 0; c < SHOW_CYC; c++) begin
            if (c > 0) tick();
            chk_out("lose_flash", outs(4'hF, 0, 0, 1, lvl));
        end
        repeat (3) begin
            tick();
            chk_out("lose_dark", outs(4'h0, 0, 0, 1, lvl));
        end
    endtask

    function automatic logic [3:0] wrong_key(input int c);
        logic [3:0] k;
        k = 4'($urandom_range(1, 15));
        if (k == oh(c)) k = oh(c) | oh((c + 1) % 4);
        return k;
    endfunction

    // lose_round==0 plays to a win; otherwise a bad press at (lose_round, lose_pos)
    task automatic play_game(input int lose_round, input int lose_pos, input bit noise);
        logic [3:0] k;
        start_game($urandom_range(0, 7));
        for (int r = 1; r <= MAX_LEN; r++) begin
            play_round(noise);
            for (int i = 0; i < exp_level; i++) begin
                repeat ($urandom_range(0, 4)) begin
                    tick();
                    chk_out("wait", outs(4'h0, 1, 0, 0, exp_level));
                end
                if (r == lose_round && i == lose_pos) k = wrong_key(exp_seq[i]);
                else                                  k = oh(exp_seq[i]);
                key = k;
                tick();
                key = 4'd0;
                if (r == lose_round && i == lose_pos) begin
                    lose_check(exp_level);
                    return;
                end
                echo(exp_seq[i], noise);
                tick();
                if (i < exp_level - 1) chk_out("wait_next", outs(4'h0, 1, 0, 0, exp_level));
            end
            if (exp_level == MAX_LEN) begin
                chk_out("win", outs(4'hF, 0, 1, 0, MAX_LEN));
                repeat (3) begin
                    tick();
                    chk_out("win_hold", outs(4'hF, 0, 1, 0, MAX_LEN));
                end
                return;
            end
            gen_step();
        end
    endtask

    typedef struct {
        int kind;
        bit exp_lose;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [3:0] k;
        int c;
        vecs = '{'{0, 1'b0}, '{1, 1'b1}, '{2, 1'b1}, '{3, 1'b1}, '{4, 1'b1}};

        #1;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_out("idle", outs(4'h0, 0, 0, 0, 0));
        end

        // First-press evaluation in WAIT_KEY
        for (int v = 0; v < 5; v++) begin
            do_reset();
            start_game($urandom_range(0, 9));
            play_round(1'b0);
            c = exp_seq[0];
            case (vecs[v].kind)
                0:       k = oh(c);
                1:       k = oh(c) | oh((c + 1) % 4);
                2:       k = oh((c + 1) % 4);
                3:       k = oh((c + 1) % 4) | oh((c + 2) % 4);
                default: k = 4'hF;
            endcase
            key = k;
            tick();
            key = 4'd0;
            chk_out($sformatf("vec%0d", v),
                    vecs[v].exp_lose ? outs(4'hF, 0, 0, 1, 1) : outs(oh(c), 1, 0, 0, 1));
        end

        // Clean win, then restart from WIN
        do_reset();
        play_game(0, 0, 1'b0);
        start_game(2);

        // Wrong second press in round 2, then restart from LOSE
        do_reset();
        play_game(2, 1, 1'b0);
        start_game(1);

        // Randomised games with noise during playback and echo
        for (int g = 0; g < 6; g++) begin
            int lr;
            do_reset();
            lr = $urandom_range(0, MAX_LEN);
            play_game(lr, (lr == 0) ? 0 : $urandom_range(0, lr - 1), 1'b1);
        end

        // Asynchronous reset in the middle of an echo
        do_reset();
        start_game(3);
        play_round(1'b0);
        key = oh(exp_seq[0]);
        tick();
        key = 4'd0;
        chk_out("echo_before_reset", outs(oh(exp_seq[0]), 1, 0, 0, 1));
        #1;
        do_reset();

        // Idle WAIT_KEY behaviour
        start_game(4);
        play_round(1'b0);
`ifdef SIMON_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            tick();
            chk_out("tmo_wait", outs(4'h0, 1, 0, 0, 1));
        end
        tick();
        chk_out("tmo_lose", outs(4'hF, 0, 0, 1, 1));
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            chk_out("wait_forever", outs(4'h0, 1, 0, 0, 1));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
